// File: rtl/register_bank_8x32_pkg.sv
// Shared sizing for the register-file storage stage and a one-hot address decoder.
// Pure declarations: no state, no latency, no flow control.
package regfile_pkg;
  localparam int WIDTH  = 32;
  localparam int NREGS  = 8;
  localparam int ADDR_W = 3;

  function automatic logic [NREGS-1:0] dec(input logic [ADDR_W-1:0] a);
    return NREGS'(1) << a;
  endfunction
endpackage

// File: rtl/register_bank_8x32_if.sv
// Write-back / issue request bus and register-bank status outputs.
// Bundle only: latency and flow control are set by the endpoints.
interface register_bank_8x32_if;
  import regfile_pkg::*;

  logic              clr;
  logic              we;
  logic [ADDR_W-1:0] wr_addr;
  logic [WIDTH-1:0]  wr_data;
  logic              issue_en;
  logic [ADDR_W-1:0] issue_addr;
  logic [WIDTH-1:0]  r0_out, r1_out, r2_out, r3_out;
  logic [WIDTH-1:0]  r4_out, r5_out, r6_out, r7_out;
  logic [NREGS-1:0]  busy;
  logic              issue_conflict;
  logic              wb_orphan;

  modport master (
    output clr, we, wr_addr, wr_data, issue_en, issue_addr,
    input  r0_out, r1_out, r2_out, r3_out, r4_out, r5_out, r6_out, r7_out,
    input  busy, issue_conflict, wb_orphan
  );

  modport slave (
    input  clr, we, wr_addr, wr_data, issue_en, issue_addr,
    output r0_out, r1_out, r2_out, r3_out, r4_out, r5_out, r6_out, r7_out,
    output busy, issue_conflict, wb_orphan
  );
endinterface

// File: rtl/register_bank_8x32_reg_cell.sv
// One data register with async reset, sync clear and write enable.
// Latency 1 cycle; always accepts, no backpressure.
module reg_cell
  import regfile_pkg::*;
#(
  parameter int W = WIDTH
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         clr,
  input  logic         we,
  input  logic [W-1:0] d,
  output logic [W-1:0] q
);
  always_ff @(posedge clk or posedge reset) begin
    if (reset)      q <= '0;
    else if (clr)   q <= '0;
    else if (we)    q <= d;
  end
endmodule

// File: rtl/register_bank_8x32.sv
// Eight 32-bit registers with one write port, pending-write scoreboard and hazard pulses.
// Write/issue visible 1 cycle after the edge; no backpressure, every request is taken.
module register_bank_8x32
  import regfile_pkg::*;
#(
  parameter bit ZERO_R0 = 1'b0
) (
  input  logic               clk,
  input  logic               reset,
  register_bank_8x32_if.slave bus
);
  localparam logic [NREGS-1:0] ADDR_MASK = {{(NREGS-1){1'b1}}, !ZERO_R0};

  logic [NREGS-1:0] wr_sel, iss_sel;
  logic [NREGS-1:0] busy_q, busy_d;
  logic             conflict_q, conflict_d;
  logic             orphan_q, orphan_d;
  logic [WIDTH-1:0] q [NREGS];

  // Register 0 is masked out of both decoders when hard-wired, so it never pulses.
  always_comb begin
    wr_sel     = bus.we       ? (dec(bus.wr_addr)    & ADDR_MASK) : '0;
    iss_sel    = bus.issue_en ? (dec(bus.issue_addr) & ADDR_MASK) : '0;
    busy_d     = (busy_q & ~wr_sel) | iss_sel;
    conflict_d = |(iss_sel & busy_q & ~wr_sel);
    orphan_d   = |(wr_sel & ~busy_q);
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      busy_q     <= '0;
      conflict_q <= 1'b0;
      orphan_q   <= 1'b0;
    end else if (bus.clr) begin
      busy_q     <= '0;
      conflict_q <= 1'b0;
      orphan_q   <= 1'b0;
    end else begin
      busy_q     <= busy_d;
      conflict_q <= conflict_d;
      orphan_q   <= orphan_d;
    end
  end

  for (genvar i = 0; i < NREGS; i++) begin : g_reg
    if (ZERO_R0 && i == 0) begin : g_zero
      assign q[i] = '0;
    end else begin : g_cell
      reg_cell #(.W(WIDTH)) u_cell (
        .clk   (clk),
        .reset (reset),
        .clr   (bus.clr),
        .we    (wr_sel[i]),
        .d     (bus.wr_data),
        .q     (q[i])
      );
    end
  end

  assign bus.r0_out         = q[0];
  assign bus.r1_out         = q[1];
  assign bus.r2_out         = q[2];
  assign bus.r3_out         = q[3];
  assign bus.r4_out         = q[4];
  assign bus.r5_out         = q[5];
  assign bus.r6_out         = q[6];
  assign bus.r7_out         = q[7];
  assign bus.busy           = busy_q;
  assign bus.issue_conflict = conflict_q;
  assign bus.wb_orphan      = orphan_q;
endmodule

// File: tb/tb_register_bank_8x32.sv
// Directed bench for register_bank_8x32: one instance with ZERO_R0=0, one with ZERO_R0=1.
module tb_register_bank_8x32;
  logic clk = 1'b0;
  logic reset = 1'b1;
  int   vectors = 0;
  int   miscompares = 0;

  always #5 clk = ~clk;

  register_bank_8x32_if bi ();
  register_bank_8x32_if bz ();

  register_bank_8x32 #(.ZERO_R0(1'b0)) dut (.clk(clk), .reset(reset), .bus(bi));
  register_bank_8x32 #(.ZERO_R0(1'b1)) dut_z (.clk(clk), .reset(reset), .bus(bz));

  function automatic logic [31:0] rd(input int i);
    case (i)
      0: return bi.r0_out;
      1: return bi.r1_out;
      2: return bi.r2_out;
      3: return bi.r3_out;
      4: return bi.r4_out;
      5: return bi.r5_out;
      6: return bi.r6_out;
      default: return bi.r7_out;
    endcase
  endfunction

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic idle();
    bi.clr = 0; bi.we = 0; bi.wr_addr = 0; bi.wr_data = 0; bi.issue_en = 0; bi.issue_addr = 0;
    bz.clr = 0; bz.we = 0; bz.wr_addr = 0; bz.wr_data = 0; bz.issue_en = 0; bz.issue_addr = 0;
  endtask

  task automatic check_status(input string tag, input logic [7:0] b, input logic c, input logic o);
    check({tag, ".busy"}, {24'h0, bi.busy}, {24'h0, b});
    check({tag, ".conflict"}, {31'h0, bi.issue_conflict}, {31'h0, c});
    check({tag, ".orphan"}, {31'h0, bi.wb_orphan}, {31'h0, o});
  endtask

  initial begin
    idle();
    #12;
    for (int i = 0; i < 8; i++) check($sformatf("reset.r%0d", i), rd(i), 32'h0);
    check_status("reset", 8'h00, 1'b0, 1'b0);
    @(negedge clk);
    reset = 0;

    // Write to a non-busy register: data lands, orphan pulses once.
    bi.we = 1; bi.wr_addr = 5; bi.wr_data = 32'hDEADBEEF;
    step(); idle();
    check("wr5.r5", rd(5), 32'hDEADBEEF);
    for (int i = 0; i < 8; i++) if (i != 5) check($sformatf("wr5.r%0d", i), rd(i), 32'h0);
    check_status("wr5", 8'h00, 1'b0, 1'b1);
    step();
    check_status("wr5.after", 8'h00, 1'b0, 1'b0);

    // Issue then write back two cycles later.
    bi.issue_en = 1; bi.issue_addr = 3;
    step(); idle();
    check_status("iss3.c1", 8'h08, 1'b0, 1'b0);
    step();
    check_status("iss3.c2", 8'h08, 1'b0, 1'b0);
    bi.we = 1; bi.wr_addr = 3; bi.wr_data = 32'h12345678;
    step(); idle();
    check("wb3.r3", rd(3), 32'h12345678);
    check_status("wb3", 8'h00, 1'b0, 1'b0);

    // Double issue to register 2.
    bi.issue_en = 1; bi.issue_addr = 2;
    step();
    check_status("iss2.a", 8'h04, 1'b0, 1'b0);
    step(); idle();
    check_status("iss2.b", 8'h04, 1'b1, 1'b0);
    step();
    check_status("iss2.c", 8'h04, 1'b0, 1'b0);

    // Same-cycle issue and write-back to a busy register 4.
    bi.issue_en = 1; bi.issue_addr = 4;
    step();
    check_status("iss4", 8'h14, 1'b0, 1'b0);
    bi.we = 1; bi.wr_addr = 4; bi.wr_data = 32'hA5A5A5A5;
    step(); idle();
    check("same4.r4", rd(4), 32'hA5A5A5A5);
    check_status("same4", 8'h14, 1'b0, 1'b0);

    // Same-cycle issue and write-back to a non-busy register 6: orphan only.
    bi.issue_en = 1; bi.issue_addr = 6; bi.we = 1; bi.wr_addr = 6; bi.wr_data = 32'h0000_6666;
    step(); idle();
    check("same6.r6", rd(6), 32'h0000_6666);
    check_status("same6", 8'h54, 1'b0, 1'b1);

    // Write-back to busy 2 and issue to 7 in the same cycle.
    bi.we = 1; bi.wr_addr = 2; bi.wr_data = 32'h2222_0002; bi.issue_en = 1; bi.issue_addr = 7;
    step(); idle();
    check("diff.r2", rd(2), 32'h2222_0002);
    check_status("diff", 8'hD0, 1'b0, 1'b0);

    // Sync clear with a concurrent write: write discarded.
    bi.clr = 1; bi.we = 1; bi.wr_addr = 1; bi.wr_data = 32'h1111_1111;
    step(); idle();
    for (int i = 0; i < 8; i++) check($sformatf("clr.r%0d", i), rd(i), 32'h0);
    check_status("clr", 8'h00, 1'b0, 1'b0);

    // Hard-wired register 0 ignores writes and issues.
    bz.we = 1; bz.wr_addr = 0; bz.wr_data = 32'hFFFFFFFF; bz.issue_en = 1; bz.issue_addr = 0;
    step();
    check("z0.r0", bz.r0_out, 32'h0);
    check("z0.busy", {24'h0, bz.busy}, 32'h0);
    check("z0.conflict", {31'h0, bz.issue_conflict}, 32'h0);
    check("z0.orphan", {31'h0, bz.wb_orphan}, 32'h0);
    bz.wr_addr = 1;
    step(); idle();
    check("z1.r0", bz.r0_out, 32'h0);
    check("z1.r1", bz.r1_out, 32'hFFFFFFFF);
    check("z1.busy", {24'h0, bz.busy}, 32'h0);
    check("z1.conflict", {31'h0, bz.issue_conflict}, 32'h0);
    check("z1.orphan", {31'h0, bz.wb_orphan}, 32'h1);

    // Asynchronous reset between edges with state loaded.
    bi.we = 1; bi.wr_addr = 7; bi.wr_data = 32'hCAFEF00D; bi.issue_en = 1; bi.issue_addr = 0;
    step(); idle();
    check("load.r7", rd(7), 32'hCAFEF00D);
    check_status("load", 8'h01, 1'b0, 1'b1);
    #2 reset = 1;
    #1;
    for (int i = 0; i < 8; i++) check($sformatf("arst.r%0d", i), rd(i), 32'h0);
    check_status("arst", 8'h00, 1'b0, 1'b0);
    reset = 0;
    bi.we = 1; bi.wr_addr = 1; bi.wr_data = 32'h0000_0001;
    step(); idle();
    check("post.r1", rd(1), 32'h0000_0001);
    check_status("post", 8'h00, 1'b0, 1'b1);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
